// File: rtl/wb_csr_master.sv
// Wishbone classic slave that initiates CSR bus accesses, one transaction at a time.
// Define CSRBRG_SEL_RMW_EN to turn partial-byte writes into read-modify-write cycles.
module wb_csr_master #(
    parameter int READ_WAIT = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [14:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_do,
    input  logic [31:0] csr_di
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
`ifdef CSRBRG_SEL_RMW_EN
        MERGE = 3'd4,
`endif
        ACK   = 3'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_dat_o;
    logic        r_ack;
    logic [14:0] r_a;
    logic        r_we;
    logic [31:0] r_do;

`ifdef CSRBRG_SEL_RMW_EN
    logic        r_rmw;
    logic [3:0]  r_sel;
    logic [31:0] w_merge;

    // r_do still carries the write data latched at accept time
    always_comb begin
        w_merge = csr_di;
        for (int b = 0; b < 4; b++)
            if (r_sel[b]) w_merge[8*b +: 8] = r_do[8*b +: 8];
    end

    logic w_unused;
    assign w_unused = ^{wb_adr_i[31:17], wb_adr_i[1:0]};
`else
    logic w_unused;
    assign w_unused = ^{wb_adr_i[31:17], wb_adr_i[1:0], wb_sel_i};
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dat_o <= '0;
            r_ack   <= 1'b0;
            r_a     <= '0;
            r_we    <= 1'b0;
            r_do    <= '0;
`ifdef CSRBRG_SEL_RMW_EN
            r_rmw   <= 1'b0;
            r_sel   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_we  <= 1'b0;
                    r_ack <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        r_a  <= wb_adr_i[16:2];
                        r_do <= wb_dat_i;
                        if (wb_we_i) begin
`ifdef CSRBRG_SEL_RMW_EN
                            r_sel <= wb_sel_i;
                            if (wb_sel_i == 4'hF) begin
                                r_we    <= 1'b1;
                                r_ack   <= 1'b1;
                                r_state <= WRITE;
                            end else if (wb_sel_i == 4'h0) begin
                                r_ack   <= 1'b1;
                                r_state <= ACK;
                            end else begin
                                r_rmw   <= 1'b1;
                                r_cnt   <= 4'(READ_WAIT);
                                r_state <= READ;
                            end
`else
                            r_we    <= 1'b1;
                            r_ack   <= 1'b1;
                            r_state <= WRITE;
`endif
                        end else begin
`ifdef CSRBRG_SEL_RMW_EN
                            r_rmw   <= 1'b0;
`endif
                            r_cnt   <= 4'(READ_WAIT);
                            r_state <= READ;
                        end
                    end
                end
                WRITE: begin
                    r_we    <= 1'b0;
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                READ: begin
                    // Master abort wins over completion: nothing is acked or written
                    if (!wb_cyc_i) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_ack <= 1'b1;
`ifdef CSRBRG_SEL_RMW_EN
                        if (r_rmw) begin
                            r_do    <= w_merge;
                            r_we    <= 1'b1;
                            r_state <= MERGE;
                        end else begin
                            r_dat_o <= csr_di;
                            r_state <= ACK;
                        end
`else
                        r_dat_o <= csr_di;
                        r_state <= ACK;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`ifdef CSRBRG_SEL_RMW_EN
                MERGE: begin
                    r_we    <= 1'b0;
                    r_ack   <= 1'b0;
                    r_rmw   <= 1'b0;
                    r_state <= IDLE;
                end
`endif
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_dat_o = r_dat_o;
    assign wb_ack_o = r_ack;
    assign csr_a    = r_a;
    assign csr_we   = r_we;
    assign csr_do   = r_do;

endmodule
